control_store: RTL

CONTROL_STORE -- requirements
Module: control_store

---
 rtl/control_store.sv | 116 +++++++++++
 1 files changed

// File: rtl/control_store.sv
// Writable microcode store with a pipeline register, condition select and
// call-depth tracking that drives an external microsequencer.
module control_store (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic [7:0]  flags,
  input  logic        stall,
  input  logic        ld_en,
  input  logic [11:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [1:0]  seq_op,
  output logic [11:0] seq_din,
  output logic [12:0] ctrl,
  output logic [11:0] uaddr,
  output logic [2:0]  depth,
  output logic        fault
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [1:0] OP_NEXT = 2'd0;
  localparam logic [1:0] OP_JUMP = 2'd1;
  localparam logic [1:0] OP_CALL = 2'd2;
  localparam logic [1:0] OP_RET  = 2'd3;

  localparam logic [2:0] MAX_DEPTH = 3'd4;

  logic [31:0] mem [4096];
  logic [31:0] pipe;
  logic [1:0]  state, state_nxt;
  logic [2:0]  depth_nxt;
  logic        fault_nxt;

  logic [1:0]  op;
  logic        inv;
  logic [3:0]  csel;
  logic [11:0] offset;
  logic [12:0] word_ctrl;
  logic        sel_flag, cond, taken, is_call, is_ret, hold;

  assign op        = pipe[31:30];
  assign inv       = pipe[29];
  assign csel      = pipe[28:25];
  assign offset    = pipe[24:13];
  assign word_ctrl = pipe[12:0];

  // csel 0..7 picks a flag, 8 is "always", 9..15 is "never"
  assign sel_flag = csel[3] ? (csel == 4'd8) : flags[csel[2:0]];
  assign cond     = sel_flag ^ inv;
  assign taken    = cond && (op != OP_NEXT);
  assign is_call  = taken && (op == OP_CALL);
  assign is_ret   = taken && (op == OP_RET);

  always_ff @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    fault_nxt = fault;
    hold      = 1'b0;
    seq_op    = OP_NEXT;
    seq_din   = 12'd0;
    ctrl      = 13'd0;
    case (state)
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (stall) begin
          hold = 1'b1;
        end else if ((is_call && depth == MAX_DEPTH) || (is_ret && depth == 3'd0)) begin
          // the offending call/return is replaced by HOLD so the sequencer never sees it
          hold      = 1'b1;
          fault_nxt = 1'b1;
          state_nxt = S_FAULT;
        end else begin
          ctrl = word_ctrl;
          if (taken) begin
            seq_op  = op;
            seq_din = offset;
          end
          if (is_call)     depth_nxt = depth + 3'd1;
          else if (is_ret) depth_nxt = depth - 3'd1;
        end
      end
      S_FAULT: hold = 1'b1;
      default: state_nxt = S_START;
    endcase
    // relative jump of -1 from uaddr+1 re-fetches the current word
    if (hold) begin
      seq_op  = OP_JUMP;
      seq_din = 12'hFFF;
      ctrl    = 13'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_START;
      pipe  <= 32'd0;
      uaddr <= 12'd0;
      depth <= 3'd0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pipe  <= mem[addr];
      uaddr <= addr;
      depth <= depth_nxt;
      fault <= fault_nxt;
    end
  end

endmodule
